// File: rtl/cmp_link_pkg.sv
// Shared types for the serial comparator link.
//   cmp_res_e   : one-hot comparator result {M,R,W}
//   cmp_state_e : driver FSM states
//   cmp_code()  : expected result for an unsigned operand pair
package cmp_link_pkg;

  // Widest operand cmp_code() accepts; callers zero-extend into it.
  localparam int CMP_MAX_W = 32;

  typedef enum logic [2:0] {
    NONE   = 3'b000,
    A_GT_B = 3'b001,
    A_EQ_B = 3'b010,
    A_LT_B = 3'b100
  } cmp_res_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT,
    HOLD
  } cmp_state_e;

  function automatic cmp_res_e cmp_code(input logic [CMP_MAX_W-1:0] a,
                                        input logic [CMP_MAX_W-1:0] b);
    if (a > b)       return A_GT_B;
    else if (a == b) return A_EQ_B;
    else             return A_LT_B;
  endfunction

endpackage

// File: rtl/cmp_serial_driver_if.sv
// Bus bundle between the operand source / result consumer / comparator and
// the serial driver.
//   master : the driver side (accepts operands, drives serial bits, returns result)
//   slave  : the environment side (offers operands, drives res_in, takes result)
interface cmp_serial_driver_if #(
  parameter int WIDTH = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_word;
  logic [WIDTH-1:0] b_word;
  logic             ser_a;
  logic             ser_b;
  logic             ser_active;
  logic             ser_first;
  logic [2:0]       res_in;
  logic             res_valid;
  logic             res_ready;
  logic [2:0]       res_data;
  logic [2:0]       res_exp;
  logic             res_ok;

  modport master (
    input  in_valid, a_word, b_word, res_in, res_ready,
    output in_ready, ser_a, ser_b, ser_active, ser_first,
           res_valid, res_data, res_exp, res_ok
  );

  modport slave (
    output in_valid, a_word, b_word, res_in, res_ready,
    input  in_ready, ser_a, ser_b, ser_active, ser_first,
           res_valid, res_data, res_exp, res_ok
  );
endinterface

// File: rtl/cmp_piso.sv
// One serial lane: VEC_W-bit parallel-in / serial-out shift register, LSB first.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture din, restart bit count
//   shift    : advance one bit
//   din      : parallel word
//   ser      : current serial bit (flop output)
//   done     : the bit now on ser is the last one of the word
module cmp_piso #(
  parameter int VEC_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [VEC_W-1:0] din,
  output logic             ser,
  output logic             done
);
  localparam int CW = $clog2(VEC_W + 1);

  logic [VEC_W-1:0] sr;
  logic [CW-1:0]    cnt;

  // Zeros shift in from the top, so the lane idles at 0 once the word is out.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= din;
      cnt <= '0;
    end else if (shift) begin
      sr  <= sr >> 1;
      cnt <= cnt + CW'(1);
    end
  end

  assign ser  = sr[0];
  assign done = (cnt == CW'(VEC_W - 1));
endmodule

// File: rtl/cmp_serial_driver.sv
// Transmit side of the serial comparator link. Captures an operand pair,
// shifts A and B out LSB first on two lanes, waits RES_LAT cycles, samples the
// comparator result and returns it with the expected code and a match flag.
//   clk, rst : clock, synchronous active-high reset
//   bus      : operand handshake, serial lanes, result handshake (master side)
module cmp_serial_driver
  import cmp_link_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int RES_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  cmp_serial_driver_if.master bus
);
  localparam int NUM_LANES = 2;
  localparam int WCW       = $clog2(RES_LAT + 1);

  cmp_state_e state_q, state_d;
  logic       load, shift, sample;

  logic [NUM_LANES-1:0][WIDTH-1:0] lane_din;
  logic [NUM_LANES-1:0]            lane_ser;
  logic [NUM_LANES-1:0]            lane_done;

  logic [WCW-1:0] wcnt_q;
  logic           wait_done;

  cmp_res_e   exp_q;
  logic [2:0] res_data_q;
  logic       res_ok_q;
  logic       in_ready_q, res_valid_q, ser_active_q, ser_first_q;

  // Lane 0 carries A, lane 1 carries B.
  assign lane_din[0] = bus.a_word;
  assign lane_din[1] = bus.b_word;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    cmp_piso #(.VEC_W(WIDTH)) u_piso (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .shift(shift),
      .din  (lane_din[l]),
      .ser  (lane_ser[l]),
      .done (lane_done[l])
    );
  end

  assign wait_done = (wcnt_q == WCW'(RES_LAT - 1));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    sample  = 1'b0;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        load    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        shift = 1'b1;
        if (&lane_done) state_d = WAIT;
      end
      WAIT: if (wait_done) begin
        sample  = 1'b1;
        state_d = HOLD;
      end
      HOLD: if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered off the next state so they line up with
  // state_q without any combinational path from the inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wcnt_q       <= '0;
      exp_q        <= NONE;
      res_data_q   <= '0;
      res_ok_q     <= 1'b0;
      in_ready_q   <= 1'b1;
      res_valid_q  <= 1'b0;
      ser_active_q <= 1'b0;
      ser_first_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= (state_d == IDLE);
      res_valid_q  <= (state_d == HOLD);
      ser_active_q <= (state_d == SHIFT);
      ser_first_q  <= load;
      wcnt_q       <= (state_q == WAIT) ? wcnt_q + WCW'(1) : '0;
      if (load)
        exp_q <= cmp_code(CMP_MAX_W'(bus.a_word), CMP_MAX_W'(bus.b_word));
      if (sample) begin
        res_data_q <= bus.res_in;
        // Full-vector compare: zero and multi-hot codes never match.
        res_ok_q   <= (bus.res_in == exp_q);
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.ser_a      = lane_ser[0];
  assign bus.ser_b      = lane_ser[1];
  assign bus.ser_active = ser_active_q;
  assign bus.ser_first  = ser_first_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_exp    = exp_q;
  assign bus.res_ok     = res_ok_q;
endmodule

// File: tb/tb_cmp_serial_driver.sv
// Bench for cmp_serial_driver: a comparator model rebuilds the operands from
// the serial lanes and drives res_in (or an override value); a scoreboard of
// expected results is filled on every accepted pair and drained on every
// result handshake.
module tb_cmp_serial_driver;
  localparam int W      = 3;
  localparam int RL     = 1;
  localparam int PERIOD = W + RL + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmp_serial_driver_if #(.WIDTH(W)) bus();

  cmp_serial_driver #(.WIDTH(W), .RES_LAT(RL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [2:0] code;
    logic [2:0] data;
    logic       ok;
  } exp_t;
  exp_t sbq[$];

  logic         ovr_en    = 1'b0;
  logic [2:0]   ovr_val   = 3'b000;
  logic [2:0]   model_res = 3'b000;
  logic [W-1:0] ra = '0, rb = '0;
  int           sidx = 0;

  assign bus.res_in = ovr_en ? ovr_val : model_res;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] tbcode(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a > b)  return 3'b001;
    if (a == b) return 3'b010;
    return 3'b100;
  endfunction

  // Scoreboard push/pop plus serial-side comparator model.
  always @(negedge clk) begin
    exp_t         e;
    int           k;
    logic [W-1:0] na, nb;
    if (rst) begin
      sbq.delete();
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        e.code = tbcode(bus.a_word, bus.b_word);
        e.data = ovr_en ? ovr_val : e.code;
        e.ok   = (e.data == e.code);
        sbq.push_back(e);
      end
      if (bus.res_valid && bus.res_ready) begin
        if (sbq.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("res_data", bus.res_data, e.data);
          chk("res_exp",  bus.res_exp,  e.code);
          chk("res_ok",   bus.res_ok,   e.ok);
        end
      end
      if (bus.ser_active) begin
        k  = bus.ser_first ? 0 : sidx;
        na = ra;
        nb = rb;
        if (k < W) begin
          na[k] = bus.ser_a;
          nb[k] = bus.ser_b;
        end
        ra   <= na;
        rb   <= nb;
        sidx <= k + 1;
        if (k == W - 1) model_res <= tbcode(na, nb);
      end
    end
  end

  // One frame with serial-lane checks; returns at the negedge of the wait cycle.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    bus.a_word   = a;
    bus.b_word   = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("ser_a",      bus.ser_a,      a[i]);
      chk("ser_b",      bus.ser_b,      b[i]);
      chk("ser_first",  bus.ser_first,  i == 0);
      chk("ser_active", bus.ser_active, 1);
      chk("busy_ready", bus.in_ready,   0);
    end
    @(negedge clk);
    chk("wait_ser_a",  bus.ser_a,      0);
    chk("wait_ser_b",  bus.ser_b,      0);
    chk("wait_active", bus.ser_active, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sbq.size(), 0);
  endtask

  initial begin
    int seen, n, last, guard;
    bus.in_valid  = 1'b0;
    bus.a_word    = '0;
    bus.b_word    = '0;
    bus.res_ready = 1'b0;

    // Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  bus.in_ready,   1);
    chk("rst_res_valid", bus.res_valid,  0);
    chk("rst_active",    bus.ser_active, 0);
    chk("rst_first",     bus.ser_first,  0);
    chk("rst_ser_a",     bus.ser_a,      0);
    chk("rst_ser_b",     bus.ser_b,      0);
    chk("rst_res_data",  bus.res_data,   0);
    chk("rst_res_ok",    bus.res_ok,     0);

    // Basic frame, model-driven result
    bus.res_ready = 1'b1;
    send(3'b110, 3'b011);
    @(negedge clk);
    chk("lat_res_valid", bus.res_valid, 1);
    drain();

    // Wrong and non-one-hot comparator codes
    ovr_en  = 1'b1;
    ovr_val = 3'b001;
    send(3'd5, 3'd5);
    drain();
    ovr_val = 3'b011;
    send(3'd1, 3'd4);
    drain();
    ovr_val = 3'b000;
    send(3'd6, 3'd1);
    drain();
    ovr_en = 1'b0;

    // Consumer stall in HOLD; in_valid pulse must be ignored
    bus.res_ready = 1'b0;
    send(3'd2, 3'd7);
    n = 0;
    while (!bus.res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reached", bus.res_valid, 1);
    bus.a_word = 3'd7;
    bus.b_word = 3'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_valid",    bus.res_valid, 1);
      chk("hold_data",     bus.res_data,  3'b100);
      chk("hold_exp",      bus.res_exp,   3'b100);
      chk("hold_ok",       bus.res_ok,    1);
      chk("hold_in_ready", bus.in_ready,  0);
      @(posedge clk); #1;
      bus.in_valid = (i == 1);
    end
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_in_ready",  bus.in_ready,  1);
    chk("release_res_valid", bus.res_valid, 0);
    chk("release_queue",     sbq.size(),    0);

    // Reset in the middle of a frame
    @(posedge clk); #1;
    bus.a_word   = 3'd3;
    bus.b_word   = 3'd1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_active",   bus.ser_active, 0);
    chk("abort_in_ready", bus.in_ready,   1);
    chk("abort_ser_a",    bus.ser_a,      0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    chk("abort_no_result", seen, 0);

    // Back-to-back random frames
    bus.res_ready = 1'b1;
    bus.a_word    = W'($urandom_range(0, 7));
    bus.b_word    = W'($urandom_range(0, 7));
    bus.in_valid  = 1'b1;
    n = 0;
    last = 0;
    guard = 0;
    while (n < 64 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (bus.in_ready) begin
        @(posedge clk); #1;
        if (n > 0) chk("accept_spacing", cyc - last, PERIOD);
        last = cyc;
        n++;
        bus.a_word = W'($urandom_range(0, 7));
        bus.b_word = (n % 5 == 0) ? bus.a_word : W'($urandom_range(0, 7));
      end
    end
    bus.in_valid = 1'b0;
    chk("btb_frames", n, 64);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
